cordic_sincos_pipe: RTL
=======================

Name: cordic_sincos_pipe

Overview:
- Parametrised, fully pipelined CORDIC sine/cosine generator with quadrant folding and modulo-360 reduction.
- Accepts one unsigned fixed-point angle in degrees per cycle and returns signed sin/cos.
- Full valid/ready backpressure on both sides: no sample is ever dropped.
- Sits between the phase/random-angle source and the complex modulator datapath; drop-in successor for the single-rate sin/cos front end.

Parameters:
- ANG_W, 25, angle width; unsigned degrees, ANG_FRAC fractional bits
- ANG_FRAC, 16, fractional bits of theta
- DATA_W, 32, signed output width
- DATA_FRAC, 16, fractional bits of sin_o/cos_o (1.0 = 2^DATA_FRAC)
- ITER, 16, number of micro-rotation stages (8..24)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- theta  in  ANG_W  input angle, degrees, unsigned Q(ANG_W-ANG_FRAC).ANG_FRAC
- vld_i  in  1  theta valid
- rdy_o  out  1  block can accept theta
- sin_o  out  DATA_W  signed sine, imaginary part
- cos_o  out  DATA_W  signed cosine, real part
- vld_o  out  1  output valid
- rdy_i  in  1  downstream ready

Interface is decided: one clock `clk`; reset `rst_n` is asynchronous, active-low.

Behaviour:
- Pipeline enable en = !(vld_o && !rdy_i); rdy_o = en.
  - All stages, data and valid, advance only when en = 1.
  - Input handshake is vld_i && rdy_o; output handshake is vld_o && rdy_i.
- Latency: exactly ITER+2 enabled cycles from input handshake to vld_o (18 at default).
  - Stage 0: reduction/fold. Stages 1..ITER: rotations. Final stage: sign correction.
- While stalled, sin_o/cos_o/vld_o hold stable. Order is preserved. Throughput is 1/cycle when rdy_i = 1.
- Bubbles (vld_i = 0) propagate as valid = 0 and do not block.
- Reset: every stage valid bit is 0; vld_o = 0, sin_o = 0, cos_o = 0; rdy_o = 1 once reset is released.
  - Reset mid-stream discards all in-flight samples; no output for them.
- Stage 0, reduction: if theta >= 360.0, subtract 360.0 once. All ANG_W = 25 codes are then < 360.0.
- Stage 0, fold on the full fixed-point value (not the integer part only), with t the reduced theta:
  - t <= 90.0: Q1, z0 = t
  - t <= 180.0: Q2, z0 = 180.0 - t
  - t <= 270.0: Q3, z0 = t - 180.0
  - else: Q4, z0 = 360.0 - t
  - Result: z0 is always in [0, 90.0].
- Rotation init: x0 = round(0.6072529350 * 2^DATA_FRAC), y0 = 0.
  - x/y are signed DATA_W+2 bits (guard bits). z is signed ANG_W+1 bits.
- Stage i (0-based): d = (z >= 0) ? +1 : -1.
  - x' = x - d*(y>>>i)
  - y' = y + d*(x>>>i)
  - z' = z - d*ATAN[i], where ATAN[i] = round(atan(2^-i)*180/pi*2^ANG_FRAC)
- Quadrant tag travels with the data. Final signs:
  - Q1: (+sin, +cos)
  - Q2: (+sin, -cos)
  - Q3: (-sin, -cos)
  - Q4: (-sin, +cos)
  - Negation is two's complement.
- Final stage saturates to the DATA_W signed range; no wrap.
- Accuracy: |error| <= 8 LSB of DATA_FRAC for ITER = 16.

Optional Feature:
- Macro CORDIC_TAG_EN. When defined:
  - Parameter TAG_W (default 8) and ports tag_i in TAG_W / tag_o out TAG_W exist.
  - tag_o is carried through every stage with the sample and is valid with vld_o; it resets to 0.
- When undefined: no tag ports and no tag registers.

Decomposition:
- Package cordic_pkg holds:
  - the ATAN table function (ANG_FRAC, ITER)
  - the K gain constant function (DATA_FRAC)
  - the 2-bit quadrant typedef (Q1..Q4)
  - the 360/180/90 fixed-point constant functions
- Sub-module cordic_stage: one registered micro-rotation, parametrised by shift index i.
  - Ports: en; in/out valid, x, y, z, quadrant; tag under the macro.
  - Instantiated ITER times via generate.

Test Plan:
- theta = 0, rdy_i = 1 -> after 18 cycles vld_o = 1, cos_o ≈ 65536, sin_o ≈ 0 (±8).
- theta = 90<<16 -> sin_o ≈ 65536, cos_o ≈ 0. theta = 210<<16 -> sin_o ≈ -32768, cos_o ≈ -56756.
- theta = 400<<16 (mod reduction) -> sin_o ≈ 42125, cos_o ≈ 50203, identical to theta = 40<<16. theta = 359.5 -> Q4 fold, sin_o ≈ -572.
- Burst of 20 back-to-back angles 0..342 step 18; rdy_i toggles 3 low / 2 high -> all 20 results in order, no loss/duplication, outputs stable while stalled, rdy_o low exactly when vld_o && !rdy_i.
- Assert rst_n low with 10 samples in flight -> vld_o = 0, outputs 0 immediately. New sample after release appears after exactly 18 cycles.
- CORDIC_TAG_EN defined, tag_i = index -> tag_o matches each output's index under random backpressure.

Source files
------------

// File: rtl/cordic_pkg.sv
// Shared types and constant helpers for the CORDIC sine/cosine pipeline.
// All functions are evaluated at elaboration time to build parameters.
package cordic_pkg;

    // Quadrant of the reduced input angle; selects the output sign correction.
    typedef enum logic [1:0] {
        QUAD_1 = 2'd0,
        QUAD_2 = 2'd1,
        QUAD_3 = 2'd2,
        QUAD_4 = 2'd3
    } quad_t;

    localparam real PI = 3.14159265358979323846;

    // Whole-degree value in unsigned fixed point with FRAC fractional bits.
    function automatic longint deg_fixed(input int deg, input int frac);
        return longint'(deg) <<< frac;
    endfunction

    function automatic longint deg_360(input int frac);
        return deg_fixed(360, frac);
    endfunction

    function automatic longint deg_180(input int frac);
        return deg_fixed(180, frac);
    endfunction

    function automatic longint deg_90(input int frac);
        return deg_fixed(90, frac);
    endfunction

    // Micro-rotation angle atan(2^-i) in degrees, rounded to FRAC fractional bits.
    function automatic int atan_fixed(input int i, input int frac);
        real a;
        a = $atan(1.0 / (2.0 ** i)) * 180.0 / PI * (2.0 ** frac);
        return $rtoi(a + 0.5);
    endfunction

    // Reciprocal CORDIC gain, pre-applied to x0 so the outputs land on unit scale.
    function automatic int gain_fixed(input int frac);
        real k;
        k = 0.6072529350 * (2.0 ** frac);
        return $rtoi(k + 0.5);
    endfunction

endpackage

// File: rtl/cordic_stage.sv
// One registered CORDIC micro-rotation with shift index SHIFT.
// Optional tag sideband when CORDIC_TAG_EN is defined.
module cordic_stage
    import cordic_pkg::*;
#(
    parameter int SHIFT    = 0,
    parameter int XW       = 34,
    parameter int ZW       = 26,
    parameter int ANG_FRAC = 16
`ifdef CORDIC_TAG_EN
    , parameter int TAG_W  = 8
`endif
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 vld_i,
    input  logic signed [XW-1:0] x_i,
    input  logic signed [XW-1:0] y_i,
    input  logic signed [ZW-1:0] z_i,
    input  logic [1:0]           quad_i,
    output logic                 vld_o,
    output logic signed [XW-1:0] x_o,
    output logic signed [XW-1:0] y_o,
    output logic signed [ZW-1:0] z_o,
    output logic [1:0]           quad_o
`ifdef CORDIC_TAG_EN
    , input  logic [TAG_W-1:0]   tag_i,
    output logic [TAG_W-1:0]     tag_o
`endif
);

    localparam logic signed [ZW-1:0] ATAN_I = ZW'(atan_fixed(SHIFT, ANG_FRAC));

    logic signed [XW-1:0] x_sh, y_sh;
    logic signed [XW-1:0] x_d, y_d;
    logic signed [ZW-1:0] z_d;

    logic                 vld_q;
    logic signed [XW-1:0] x_q, y_q;
    logic signed [ZW-1:0] z_q;
    logic [1:0]           quad_q;

    // Rotate toward z = 0: direction follows the sign of the residual angle.
    always_comb begin
        x_sh = x_i >>> SHIFT;
        y_sh = y_i >>> SHIFT;
        if (!z_i[ZW-1]) begin
            x_d = x_i - y_sh;
            y_d = y_i + x_sh;
            z_d = z_i - ATAN_I;
        end else begin
            x_d = x_i + y_sh;
            y_d = y_i - x_sh;
            z_d = z_i + ATAN_I;
        end
    end

    // Stage register; the whole pipeline freezes together when en is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q  <= 1'b0;
            x_q    <= '0;
            y_q    <= '0;
            z_q    <= '0;
            quad_q <= QUAD_1;
        end else if (en) begin
            vld_q  <= vld_i;
            x_q    <= x_d;
            y_q    <= y_d;
            z_q    <= z_d;
            quad_q <= quad_i;
        end
    end

`ifdef CORDIC_TAG_EN
    logic [TAG_W-1:0] tag_q;

    // Tag travels in lockstep with the sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_q <= '0;
        end else if (en) begin
            tag_q <= tag_i;
        end
    end

    assign tag_o = tag_q;
`endif

    assign vld_o  = vld_q;
    assign x_o    = x_q;
    assign y_o    = y_q;
    assign z_o    = z_q;
    assign quad_o = quad_q;

endmodule

// File: rtl/cordic_sincos_pipe.sv
// Fully pipelined CORDIC sine/cosine generator with modulo-360 reduction,
// quadrant folding and saturating sign correction. Angle input is unsigned
// degrees; outputs are signed with DATA_FRAC fractional bits.
// Pipeline: fold register, ITER rotation stages, output register (ITER+2).
// Optional macro CORDIC_TAG_EN adds a TAG_W sideband carried with each sample.
module cordic_sincos_pipe
    import cordic_pkg::*;
#(
    parameter int ANG_W     = 25,
    parameter int ANG_FRAC  = 16,
    parameter int DATA_W    = 32,
    parameter int DATA_FRAC = 16,
    parameter int ITER      = 16
`ifdef CORDIC_TAG_EN
    , parameter int TAG_W   = 8
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ANG_W-1:0]  theta,
    input  logic              vld_i,
    output logic              rdy_o,
    output logic [DATA_W-1:0] sin_o,
    output logic [DATA_W-1:0] cos_o,
    output logic              vld_o,
    input  logic              rdy_i
`ifdef CORDIC_TAG_EN
    , input  logic [TAG_W-1:0] tag_i,
    output logic [TAG_W-1:0]   tag_o
`endif
);

    localparam int XW = DATA_W + 2;
    localparam int ZW = ANG_W + 1;

    localparam logic [ZW-1:0]        C360   = ZW'(deg_360(ANG_FRAC));
    localparam logic [ZW-1:0]        C180   = ZW'(deg_180(ANG_FRAC));
    localparam logic [ZW-1:0]        C90    = ZW'(deg_90(ANG_FRAC));
    localparam logic [ZW-1:0]        C270   = C180 + C90;
    localparam logic signed [XW-1:0] X_INIT = XW'(gain_fixed(DATA_FRAC));

    logic en;

    // Stage 0 signals
    logic [ZW-1:0]        theta_ext;
    logic [ZW-1:0]        t_red;
    logic [ZW-1:0]        z0_d;
    quad_t                quad_d;
    logic                 vld0_q;
    logic signed [ZW-1:0] z0_q;
    logic [1:0]           quad0_q;

    // Rotation chain, index 0 is the fold stage output
    logic                 vld_s  [ITER+1];
    logic signed [XW-1:0] x_s    [ITER+1];
    logic signed [XW-1:0] y_s    [ITER+1];
    logic signed [ZW-1:0] z_s    [ITER+1];
    logic [1:0]           quad_s [ITER+1];

    // Output stage signals
    quad_t                quad_f;
    logic signed [XW-1:0] cos_pre, sin_pre;
    logic [DATA_W-1:0]    cos_d, sin_d;
    logic                 vld_q;
    logic [DATA_W-1:0]    cos_q, sin_q;

    // Clamp a guard-extended value into the DATA_W signed range.
    function automatic logic [DATA_W-1:0] sat(input logic signed [XW-1:0] v);
        if (v[XW-1:DATA_W-1] == '0 || v[XW-1:DATA_W-1] == '1) begin
            return v[DATA_W-1:0];
        end else if (v[XW-1]) begin
            return {1'b1, {(DATA_W-1){1'b0}}};
        end else begin
            return {1'b0, {(DATA_W-1){1'b1}}};
        end
    endfunction

    // A full output register that is not being taken stalls every stage.
    assign en    = !(vld_q && !rdy_i);
    assign rdy_o = en;

    // Reduce once modulo 360, then fold onto [0, 90] and remember the quadrant.
    always_comb begin
        theta_ext = {1'b0, theta};
        t_red     = (theta_ext >= C360) ? (theta_ext - C360) : theta_ext;
        z0_d      = t_red;
        quad_d    = QUAD_1;
        if (t_red <= C90) begin
            quad_d = QUAD_1;
            z0_d   = t_red;
        end else if (t_red <= C180) begin
            quad_d = QUAD_2;
            z0_d   = C180 - t_red;
        end else if (t_red <= C270) begin
            quad_d = QUAD_3;
            z0_d   = t_red - C180;
        end else begin
            quad_d = QUAD_4;
            z0_d   = C360 - t_red;
        end
    end

    // Fold stage register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld0_q  <= 1'b0;
            z0_q    <= '0;
            quad0_q <= QUAD_1;
        end else if (en) begin
            vld0_q  <= vld_i;
            z0_q    <= $signed(z0_d);
            quad0_q <= quad_d;
        end
    end

    // x0/y0 are constants, so the fold stage only needs to register z.
    assign vld_s[0]  = vld0_q;
    assign x_s[0]    = X_INIT;
    assign y_s[0]    = '0;
    assign z_s[0]    = z0_q;
    assign quad_s[0] = quad0_q;

`ifdef CORDIC_TAG_EN
    logic [TAG_W-1:0] tag0_q;
    logic [TAG_W-1:0] tag_s [ITER+1];
    logic [TAG_W-1:0] tag_q;

    // Tag capture alongside the fold stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag0_q <= '0;
        end else if (en) begin
            tag0_q <= tag_i;
        end
    end

    assign tag_s[0] = tag0_q;
`endif

    for (genvar i = 0; i < ITER; i++) begin : g_rot
        cordic_stage #(
            .SHIFT    (i),
            .XW       (XW),
            .ZW       (ZW),
            .ANG_FRAC (ANG_FRAC)
`ifdef CORDIC_TAG_EN
            , .TAG_W  (TAG_W)
`endif
        ) u_stage (
            .clk    (clk),
            .rst_n  (rst_n),
            .en     (en),
            .vld_i  (vld_s[i]),
            .x_i    (x_s[i]),
            .y_i    (y_s[i]),
            .z_i    (z_s[i]),
            .quad_i (quad_s[i]),
            .vld_o  (vld_s[i+1]),
            .x_o    (x_s[i+1]),
            .y_o    (y_s[i+1]),
            .z_o    (z_s[i+1]),
            .quad_o (quad_s[i+1])
`ifdef CORDIC_TAG_EN
            , .tag_i (tag_s[i]),
            .tag_o   (tag_s[i+1])
`endif
        );
    end

    // Unfold: restore signs from the quadrant, then saturate.
    always_comb begin
        quad_f  = quad_t'(quad_s[ITER]);
        cos_pre = (quad_f == QUAD_2 || quad_f == QUAD_3) ? -x_s[ITER] : x_s[ITER];
        sin_pre = (quad_f == QUAD_3 || quad_f == QUAD_4) ? -y_s[ITER] : y_s[ITER];
        cos_d   = sat(cos_pre);
        sin_d   = sat(sin_pre);
    end

    // Output register; holds while the downstream is not ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= 1'b0;
            cos_q <= '0;
            sin_q <= '0;
        end else if (en) begin
            vld_q <= vld_s[ITER];
            cos_q <= cos_d;
            sin_q <= sin_d;
        end
    end

`ifdef CORDIC_TAG_EN
    // Output tag register, valid together with vld_o.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_q <= '0;
        end else if (en) begin
            tag_q <= tag_s[ITER];
        end
    end

    assign tag_o = tag_q;
`endif

    assign vld_o = vld_q;
    assign sin_o = sin_q;
    assign cos_o = cos_q;

endmodule
